// File: rtl/idelay_init_seq.sv
// IDELAYCTRL bring-up sequencer: pulses idelay_rst, waits for ready with timeout/retry, reports ready or fault.
// Optional macro IDELAY_RDY_MONITOR_EN: losing ready while in READY restarts the sequence.
module idelay_init_seq #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_reinit,
    input  logic       idelay_rdy,
    output logic       idelay_rst,
    output logic       dly_ready,
    output logic       dly_fault,
    output logic [3:0] retry_cnt
);

    typedef enum logic [1:0] {
        PULSE    = 2'd0,
        WAIT_RDY = 2'd1,
        READY    = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [3:0]  retry_nxt;
    logic        rdy_meta;
    logic        rdy_s;

    // idelay_rdy comes from the IDELAYCTRL domain; two flops before any decision uses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= idelay_rdy;
            rdy_s    <= rdy_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        if (soft_reinit) begin
            state_nxt = PULSE;
            cnt_nxt   = 16'd0;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                PULSE: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = WAIT_RDY;
                        cnt_nxt   = 16'd0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                WAIT_RDY: begin
                    // A ready arriving on the timeout cycle still counts as success.
                    if (rdy_s) begin
                        state_nxt = READY;
                        cnt_nxt   = 16'd0;
                    end else if (cnt == TO_LAST) begin
                        cnt_nxt = 16'd0;
                        if (retry_cnt < RETRY_MAX) begin
                            state_nxt = PULSE;
                            retry_nxt = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
                        end else begin
                            state_nxt = FAULT;
                        end
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                READY: begin
`ifdef IDELAY_RDY_MONITOR_EN
                    if (!rdy_s) begin
                        state_nxt = PULSE;
                        cnt_nxt   = 16'd0;
                        retry_nxt = 4'd0;
                    end
`endif
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = PULSE;
                    cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PULSE;
            cnt        <= 16'd0;
            retry_cnt  <= 4'd0;
            idelay_rst <= 1'b1;
            dly_ready  <= 1'b0;
            dly_fault  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retry_cnt  <= retry_nxt;
            idelay_rst <= (state_nxt == PULSE);
            dly_ready  <= (state_nxt == READY);
            dly_fault  <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_idelay_init_seq.sv
// Bench for idelay_init_seq: directed tables and sequences, then random stimulus against a countdown-style model.
module tb_idelay_init_seq;

    localparam int RSTC = 16;
    localparam int TOC  = 64;
    localparam int MAXR = 2;

    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_READY = 2;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_reinit = 1'b0;
    logic       idelay_rdy = 1'b0;
    logic       idelay_rst;
    logic       dly_ready;
    logic       dly_fault;
    logic [3:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: phase, pulse countdown, wait elapsed, retry tally, synchronizer pipe.
    int m_mode;
    int m_left;
    int m_elapsed;
    int m_retry;
    bit m_s1;
    bit m_s2;

    typedef struct {
        string      name;
        int         k;
        logic       e_rst;
        logic       e_rdy;
        logic       e_flt;
        logic [3:0] e_retry;
    } vec_t;

    vec_t tbl[12];

    idelay_init_seq #(
        .RST_CYCLES(RSTC),
        .TIMEOUT_CYCLES(TOC),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .soft_reinit(soft_reinit),
        .idelay_rdy(idelay_rdy),
        .idelay_rst(idelay_rst),
        .dly_ready(dly_ready),
        .dly_fault(dly_fault),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_PULSE;
        m_left    = RSTC;
        m_elapsed = 0;
        m_retry   = 0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
    endtask

    task automatic model_step();
        bit rs;
        rs   = m_s2;
        m_s2 = m_s1;
        m_s1 = idelay_rdy;
        if (soft_reinit) begin
            m_mode  = M_PULSE;
            m_left  = RSTC;
            m_retry = 0;
        end else begin
            case (m_mode)
                M_PULSE: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode    = M_WAIT;
                        m_elapsed = 0;
                    end
                end
                M_WAIT: begin
                    if (rs) begin
                        m_mode = M_READY;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == TOC) begin
                            if (m_retry < MAXR) begin
                                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                                m_mode  = M_PULSE;
                                m_left  = RSTC;
                            end else begin
                                m_mode = M_FAULT;
                            end
                        end
                    end
                end
                M_READY: begin
`ifdef IDELAY_RDY_MONITOR_EN
                    if (!rs) begin
                        m_mode  = M_PULSE;
                        m_left  = RSTC;
                        m_retry = 0;
                    end
`endif
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model(input string name);
        logic [6:0] exp;
        exp = {m_mode == M_PULSE, m_mode == M_READY, m_mode == M_FAULT, 4'(m_retry)};
        check(name, {9'd0, idelay_rst, dly_ready, dly_fault, retry_cnt}, {9'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    // Asserts rst mid-cycle, checks the outputs before any clock edge, then releases after two edges.
    task automatic apply_rst(input string name);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check({name, "_idelay_rst"}, idelay_rst, 1);
        check({name, "_dly_ready"}, dly_ready, 0);
        check({name, "_dly_fault"}, dly_fault, 0);
        check({name, "_retry"}, retry_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic count_pulse(input string name);
        int n;
        n = 0;
        while (idelay_rst === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check(name, n, RSTC);
    endtask

    initial begin
        int k;
        int hold;

        tbl[0]  = '{"p0_end",     15,  1, 0, 0, 4'd0};
        tbl[1]  = '{"w0_start",   16,  0, 0, 0, 4'd0};
        tbl[2]  = '{"w0_end",     79,  0, 0, 0, 4'd0};
        tbl[3]  = '{"p1_start",   80,  1, 0, 0, 4'd1};
        tbl[4]  = '{"p1_end",     95,  1, 0, 0, 4'd1};
        tbl[5]  = '{"w1_start",   96,  0, 0, 0, 4'd1};
        tbl[6]  = '{"p2_start",   160, 1, 0, 0, 4'd2};
        tbl[7]  = '{"p2_end",     175, 1, 0, 0, 4'd2};
        tbl[8]  = '{"w2_start",   176, 0, 0, 0, 4'd2};
        tbl[9]  = '{"w2_end",     239, 0, 0, 0, 4'd2};
        tbl[10] = '{"fault_in",   240, 0, 0, 1, 4'd2};
        tbl[11] = '{"fault_hold", 300, 0, 0, 1, 4'd2};

        // Power-on reset
        model_reset();
        tick();
        check("por_idelay_rst", idelay_rst, 1);
        check("por_dly_ready", dly_ready, 0);
        check("por_dly_fault", dly_fault, 0);
        check("por_retry", retry_cnt, 0);
        tick();
        rst = 1'b0;

        // First pulse, then ready arrives 10 cycles after the fall
        count_pulse("first_pulse_len");
        repeat (10) tick();
        idelay_rdy = 1'b1;
        repeat (2) tick();
        check("ready_not_early", dly_ready, 0);
        tick();
        check("ready_latency", dly_ready, 1);
        check("ready_retry", retry_cnt, 0);

        // Ready drops for 3 cycles while READY
        idelay_rdy = 1'b0;
        repeat (2) tick();
        check("drop_ready_hold", dly_ready, 1);
        tick();
        idelay_rdy = 1'b1;
`ifdef IDELAY_RDY_MONITOR_EN
        check("mon_drop_ready", dly_ready, 0);
        check("mon_drop_pulse", idelay_rst, 1);
        count_pulse("mon_pulse_len");
        tick();
        check("mon_ready_again", dly_ready, 1);
`else
        check("sticky_ready", dly_ready, 1);
        idelay_rdy = 1'b0;
        repeat (100) tick();
        check("sticky_ready_long", dly_ready, 1);
        check("sticky_no_pulse", idelay_rst, 0);
        idelay_rdy = 1'b1;
`endif

        // Async reset from READY, then from WAIT_RDY cycle 30
        apply_rst("rst_ready");
        idelay_rdy = 1'b0;
        repeat (RSTC + 30) tick();
        check("mid_wait_idelay_rst", idelay_rst, 0);
        apply_rst("rst_wait");
        count_pulse("pulse_after_rst");

        // Retry ladder into FAULT, checked against a fixed table
        apply_rst("rst_table");
        k = 0;
        for (int i = 0; i < 12; i++) begin
            while (k < tbl[i].k) begin
                tick();
                k++;
            end
            check({tbl[i].name, "_idelay_rst"}, idelay_rst, tbl[i].e_rst);
            check({tbl[i].name, "_dly_ready"}, dly_ready, tbl[i].e_rdy);
            check({tbl[i].name, "_dly_fault"}, dly_fault, tbl[i].e_flt);
            check({tbl[i].name, "_retry"}, retry_cnt, tbl[i].e_retry);
        end

        // soft_reinit out of FAULT
        idelay_rdy  = 1'b1;
        soft_reinit = 1'b1;
        tick();
        soft_reinit = 1'b0;
        check("reinit_fault_clear", dly_fault, 0);
        check("reinit_idelay_rst", idelay_rst, 1);
        check("reinit_retry", retry_cnt, 0);
        count_pulse("reinit_pulse_len");
        tick();
        check("reinit_ready", dly_ready, 1);
        check("reinit_ready_retry", retry_cnt, 0);

        // soft_reinit held for several cycles restarts the pulse each cycle
        soft_reinit = 1'b1;
        repeat (5) tick();
        check("held_soft_idelay_rst", idelay_rst, 1);
        check("held_soft_dly_ready", dly_ready, 0);
        soft_reinit = 1'b0;
        count_pulse("held_soft_pulse_len");
        tick();
        check("held_soft_ready", dly_ready, 1);

        // soft_reinit on the same edge that rdy_s would complete WAIT_RDY
        idelay_rdy = 1'b0;
        apply_rst("rst_collide");
        count_pulse("collide_pulse_len");
        repeat (5) tick();
        idelay_rdy = 1'b1;
        repeat (2) tick();
        soft_reinit = 1'b1;
        tick();
        soft_reinit = 1'b0;
        check("collide_idelay_rst", idelay_rst, 1);
        check("collide_dly_ready", dly_ready, 0);
        tick();
        check("collide_ready_stays_0", dly_ready, 0);

        // Random stimulus against the model
        apply_rst("rst_rand");
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                idelay_rdy = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 150);
            end else begin
                hold--;
            end
            soft_reinit = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 799) == 0) apply_rst("rand_rst");
            tick();
            check_model("rand");
            check("rand_excl", {15'd0, dly_ready & dly_fault}, 16'd0);
        end
        soft_reinit = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idelay_init_seq.md
IDELAY_INIT_SEQ -- requirements
Module: idelay_init_seq

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, giving the idelay_rst pulse length in clk cycles; legal range 4..255.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the maximum wait for ready after pulse release; legal range 8..65535.
REQ-003 The block SHALL have parameter MAX_RETRIES, default 3, giving the number of re-pulses after the first attempt; legal range 0..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port soft_reinit, input, 1 bit: single-cycle synchronous request to restart the sequence.
REQ-007 The block SHALL have port idelay_rdy, input, 1 bit: the IDELAYCTRL ready flag, asynchronous to clk.
REQ-008 The block SHALL have port idelay_rst, output, 1 bit: the reset driven to IDELAYCTRL.
REQ-009 The block SHALL have port dly_ready, output, 1 bit: the calibrated-and-stable status flag.
REQ-010 The block SHALL have port dly_fault, output, 1 bit: the retries-exhausted flag.
REQ-011 The block SHALL have port retry_cnt, output, 4 bits: the number of timeouts in the current sequence.

Function
REQ-012 idelay_rdy SHALL pass through a 2-flop synchronizer; rdy_s denotes its output, 2 cycles of latency.
REQ-013 The FSM SHALL have states PULSE, WAIT_RDY, READY and FAULT, with outputs registered.
REQ-014 In PULSE, idelay_rst=1 for exactly RST_CYCLES cycles, then the FSM SHALL move to WAIT_RDY with the timeout counter cleared.
REQ-015 In WAIT_RDY, idelay_rst=0; rdy_s=1 SHALL move the FSM to READY, with dly_ready=1 on the following cycle.
REQ-016 If WAIT_RDY lasts TIMEOUT_CYCLES cycles without rdy_s, then: if retry_cnt<MAX_RETRIES, retry_cnt SHALL increment and the FSM SHALL return to PULSE; otherwise it SHALL go to FAULT.
REQ-017 In FAULT, dly_fault=1, idelay_rst=0 and dly_ready=0; only soft_reinit or rst SHALL exit FAULT.
REQ-018 soft_reinit=1 in any state SHALL force PULSE and clear retry_cnt, with dly_ready=0 and dly_fault=0 from the next cycle.
REQ-019 When soft_reinit and rdy_s rise in the same cycle, soft_reinit SHALL win.
REQ-020 When the timeout expires and rdy_s rises in the same cycle, rdy_s SHALL win and the FSM SHALL go to READY.
REQ-021 soft_reinit held high for multiple cycles SHALL keep the FSM in PULSE with the pulse counter restarted each cycle.
REQ-022 retry_cnt SHALL saturate at 15 and never wrap.
REQ-023 dly_ready and dly_fault SHALL never be 1 simultaneously.

Reset
REQ-024 When rst=1, the block SHALL asynchronously set state=PULSE, idelay_rst=1, dly_ready=0, dly_fault=0, retry_cnt=0, all counters=0 and synchronizer flops=0.
REQ-025 On rst deassertion, the block SHALL hold idelay_rst=1 for a full RST_CYCLES count, even when rst was asserted mid-sequence.

Configuration
REQ-026 With macro IDELAY_RDY_MONITOR_EN defined, rdy_s=0 for 1 cycle while in READY SHALL clear dly_ready next cycle and enter PULSE with retry_cnt cleared.
REQ-027 Without IDELAY_RDY_MONITOR_EN, READY SHALL be sticky, idelay_rdy SHALL be ignored once READY is reached, and only rst or soft_reinit SHALL leave READY.

Verification (RST_CYCLES=16, TIMEOUT_CYCLES=64, MAX_RETRIES=2)
REQ-028 Release rst, then raise idelay_rdy 10 cycles after idelay_rst falls -> idelay_rst high exactly 16 cycles, dly_ready=1 by 13 cycles after the fall, retry_cnt=0.
REQ-029 Hold idelay_rdy=0 -> three 16-cycle pulses separated by 64-cycle waits, retry_cnt 0->1->2, then dly_fault=1 with idelay_rst=0 held.
REQ-030 From FAULT, pulse soft_reinit 1 cycle with idelay_rdy=1 -> dly_fault=0 next cycle, 16-cycle pulse, then dly_ready=1, retry_cnt=0.
REQ-031 In READY, drop idelay_rdy for 3 cycles -> with IDELAY_RDY_MONITOR_EN, dly_ready falls 3 cycles after the drop and a new 16-cycle pulse starts; without it, dly_ready stays 1.
REQ-032 Assert rst asynchronously mid-WAIT_RDY (cycle 30) -> idelay_rst=1 and dly_ready=0 immediately, without waiting for a clk edge; after release, a full 16-cycle pulse.
REQ-033 Assert soft_reinit in the same cycle that rdy_s rises in WAIT_RDY -> FSM enters PULSE and dly_ready stays 0.
